// File: rtl/alu_pkg.sv
// Shared widths, opcodes and FSM state encoding for the execute/writeback stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_exec_mul8_serial.sv
// Serial shift-add 8x8 multiplier producing a 16-bit product.
// Latency: 8 busy cycles after start; done is high during the 8th, with product valid then.
// Backpressure: none; start is ignored only under reset, the owner must not restart while busy.
module mul8_serial
  import alu_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  logic                busy;
  logic [DATA_W-1:0]   mcand;
  logic [DATA_W-1:0]   mplier;
  logic [2*DATA_W-1:0] acc;
  logic [2:0]          step;
  logic [2*DATA_W-1:0] addend;

  // Partial product for this step; product is the accumulator after this step,
  // so on the final step it already holds the full result.
  always_comb begin
    addend = '0;
    if (mplier[0]) begin
      addend = {{DATA_W{1'b0}}, mcand} << step;
    end
    product = acc + addend;
  end

  assign done = busy && (step == 3'd7);

  // Operand capture on start, then one shift-add step per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy   <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      step   <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      step   <= '0;
    end else if (busy) begin
      acc    <= product;
      mplier <= mplier >> 1;
      step   <= step + 3'd1;
      if (step == 3'd7) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Execute/writeback stage: ALU ops and serial multiply feeding the register file write port.
// Latency: single-cycle ops write next cycle; MUL writes 9 cycles after acceptance.
// Backpressure: ready_o drops for the 8 multiply cycles; upstream holds its instruction.
module alu_exec
  import alu_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [2:0]        op_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  output logic [ADDR_W-1:0] rs_addr_o,
  output logic [ADDR_W-1:0] rt_addr_o,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  output logic              write_o,
  output logic [ADDR_W-1:0] write_addr_o,
  output logic [DATA_W-1:0] write_data_o,
  output logic              carry_o
);

  state_t              state;
  logic [ADDR_W-1:0]   mul_rd;
  logic [DATA_W-1:0]   op_a;
  logic [DATA_W-1:0]   op_b;
  logic [DATA_W:0]     sum;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_carry;
  logic                alu_wr;
  logic                mul_start;
  logic                mul_done;
  logic [2*DATA_W-1:0] mul_product;

  assign rs_addr_o = rs_addr_i;
  assign rt_addr_o = rt_addr_i;
  assign ready_o   = (state == S_IDLE);
  assign mul_start = valid_i && ready_o && (op_i == OP_MUL);

  // The register file commits write_o at the end of this cycle, so a reader
  // of that register this cycle must take the value straight off the port.
  always_comb begin
    op_a = rs_data_i;
    op_b = rt_data_i;
    if (write_o && (write_addr_o == rs_addr_i)) op_a = write_data_o;
    if (write_o && (write_addr_o == rt_addr_i)) op_b = write_data_o;
  end

  // Single-cycle ALU; logic ops and shifts leave the carry flag alone.
  always_comb begin
    sum       = '0;
    alu_res   = '0;
    alu_carry = carry_o;
    alu_wr    = 1'b0;
    case (op_i)
      OP_ADD: begin
        sum       = {1'b0, op_a} + {1'b0, op_b};
        alu_res   = sum[DATA_W-1:0];
        alu_carry = sum[DATA_W];
        alu_wr    = 1'b1;
      end
      OP_SUB: begin
        sum       = {1'b0, op_a} + {1'b0, ~op_b} + {{DATA_W{1'b0}}, 1'b1};
        alu_res   = sum[DATA_W-1:0];
        alu_carry = sum[DATA_W];
        alu_wr    = 1'b1;
      end
      OP_AND: begin
        alu_res = op_a & op_b;
        alu_wr  = 1'b1;
      end
      OP_OR: begin
        alu_res = op_a | op_b;
        alu_wr  = 1'b1;
      end
      OP_XOR: begin
        alu_res = op_a ^ op_b;
        alu_wr  = 1'b1;
      end
      OP_SLL: begin
        alu_res = op_a << op_b[2:0];
        alu_wr  = 1'b1;
      end
      default: begin
      end
    endcase
  end

  mul8_serial u_mul (
    .clk     (clk_i),
    .reset   (reset_i),
    .start   (mul_start),
    .a       (op_a),
    .b       (op_b),
    .done    (mul_done),
    .product (mul_product)
  );

  // Issue FSM and registered write port; write_o is a one-cycle pulse.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state        <= S_IDLE;
      write_o      <= 1'b0;
      write_addr_o <= '0;
      write_data_o <= '0;
      carry_o      <= 1'b0;
      mul_rd       <= '0;
    end else begin
      write_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (valid_i) begin
            if (op_i == OP_MUL) begin
              state  <= S_MUL;
              mul_rd <= rd_addr_i;
            end else if (alu_wr) begin
              write_o      <= 1'b1;
              write_addr_o <= rd_addr_i;
              write_data_o <= alu_res;
              carry_o      <= alu_carry;
            end
          end
        end
        S_MUL: begin
          if (mul_done) begin
            state        <= S_IDLE;
            write_o      <= 1'b1;
            write_addr_o <= mul_rd;
            write_data_o <= mul_product[DATA_W-1:0];
            carry_o      <= |mul_product[2*DATA_W-1:DATA_W];
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Randomized bench for alu_exec against a sequential architectural model.
// The model commits each accepted instruction immediately and predicts when its write appears.
// The bench also plays the register file and holds instructions while ready_o is low.
module tb_alu_exec;
  import alu_pkg::*;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       valid_i;
  logic       ready_o;
  logic [2:0] op_i, rd_addr_i, rs_addr_i, rt_addr_i;
  logic [2:0] rs_addr_o, rt_addr_o, write_addr_o;
  logic [7:0] rs_data_i, rt_data_i, write_data_o;
  logic       write_o, carry_o;

  alu_exec dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .op_i         (op_i),
    .rd_addr_i    (rd_addr_i),
    .rs_addr_i    (rs_addr_i),
    .rt_addr_i    (rt_addr_i),
    .rs_addr_o    (rs_addr_o),
    .rt_addr_o    (rt_addr_o),
    .rs_data_i    (rs_data_i),
    .rt_data_i    (rt_data_i),
    .write_o      (write_o),
    .write_addr_o (write_addr_o),
    .write_data_o (write_data_o),
    .carry_o      (carry_o)
  );

  always #5 clk_i = ~clk_i;

  // Register file environment: DUT writes, plus a preload port for setup.
  logic [7:0] rf [8];
  logic       pre_en;
  logic [2:0] pre_addr;
  logic [7:0] pre_val;

  always @(posedge clk_i) begin
    if (write_o) rf[write_addr_o] <= write_data_o;
    else if (pre_en) rf[pre_addr] <= pre_val;
  end

  assign rs_data_i = rf[rs_addr_o];
  assign rt_data_i = rf[rt_addr_o];

  typedef struct {
    int         due;
    logic [2:0] rd;
    logic [7:0] res;
    logic       cupd;
    logic       c;
    logic [7:0] old;
  } pend_t;

  pend_t q[$];
  int    ref_rf [8];
  logic  mcarry;
  int    total, bad, cyc, busy_lo, busy_hi, rst_chk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit model_busy();
    return (cyc >= busy_lo) && (cyc < busy_hi);
  endfunction

  // One clock: sample outputs mid-cycle and compare with the model's predictions.
  task automatic tick();
    bit exp_w;
    @(negedge clk_i);
    cyc++;
    exp_w = (q.size() > 0) && (q[0].due == cyc);
    chk("write_en", 16'(write_o), 16'(exp_w));
    if (exp_w) begin
      chk("write_addr", 16'(write_addr_o), 16'(q[0].rd));
      chk("write_data", 16'(write_data_o), 16'(q[0].res));
      if (q[0].cupd) mcarry = q[0].c;
      void'(q.pop_front());
    end
    chk("carry", 16'(carry_o), 16'(mcarry));
    chk("ready", 16'(ready_o), 16'(!model_busy()));
    if (cyc == rst_chk) begin
      chk("rst_wdata", 16'(write_data_o), 16'h0);
      chk("rst_waddr", 16'(write_addr_o), 16'h0);
    end
  endtask

  // Architectural effect of one instruction, with its predicted write cycle.
  task automatic model_accept(input logic [2:0] op, input logic [2:0] rd,
                              input logic [2:0] rs, input logic [2:0] rt);
    int    a, b, r;
    pend_t p;
    a = ref_rf[rs];
    b = ref_rf[rt];
    r = 0;
    p.cupd = 1'b0;
    p.c    = 1'b0;
    case (op)
      OP_ADD: begin r = a + b; p.c = (r > 255); p.cupd = 1'b1; end
      OP_SUB: begin r = a - b + 256; p.c = (a >= b); p.cupd = 1'b1; end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_SLL: r = a << (b % 8);
      OP_MUL: begin r = a * b; p.c = (r > 255); p.cupd = 1'b1; end
      default: return;
    endcase
    r = r % 256;
    p.due = cyc + ((op == OP_MUL) ? 9 : 1);
    p.rd  = rd;
    p.res = 8'(r);
    p.old = 8'(ref_rf[rd]);
    ref_rf[rd] = r;
    q.push_back(p);
    if (op == OP_MUL) begin
      busy_lo = cyc + 1;
      busy_hi = cyc + 9;
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [2:0] rd,
                      input logic [2:0] rs, input logic [2:0] rt);
    int waited;
    waited    = 0;
    op_i      = op;
    rd_addr_i = rd;
    rs_addr_i = rs;
    rt_addr_i = rt;
    valid_i   = 1'b1;
    #1;
    chk("rs_pass", 16'(rs_addr_o), 16'(rs));
    chk("rt_pass", 16'(rt_addr_o), 16'(rt));
    while (model_busy() && waited <= 20) begin
      tick();
      waited++;
    end
    if (waited > 20) chk("accept_timeout", 16'(waited), 16'd20);
    model_accept(op, rd, rs, rt);
    tick();
    valid_i = 1'b0;
  endtask

  // Reset drops any write still in flight, so the model rolls those back.
  task automatic do_reset();
    pend_t p;
    reset_i = 1'b1;
    valid_i = 1'b0;
    while (q.size() > 0) begin
      p = q.pop_back();
      ref_rf[p.rd] = p.old;
    end
    mcarry  = 1'b0;
    busy_lo = 0;
    busy_hi = 0;
    rst_chk = cyc + 1;
    tick();
    reset_i = 1'b0;
  endtask

  task automatic preload(input logic [2:0] a, input logic [7:0] v);
    pre_en   = 1'b1;
    pre_addr = a;
    pre_val  = v;
    ref_rf[a] = int'(v);
    tick();
    pre_en = 1'b0;
  endtask

  initial begin
    reset_i   = 1'b1;
    valid_i   = 1'b0;
    op_i      = OP_NOP;
    rd_addr_i = '0;
    rs_addr_i = '0;
    rt_addr_i = '0;
    pre_en    = 1'b0;
    pre_addr  = '0;
    pre_val   = '0;
    mcarry    = 1'b0;
    total     = 0;
    bad       = 0;
    cyc       = 0;
    busy_lo   = 0;
    busy_hi   = 0;
    rst_chk   = -1;
    for (int i = 0; i < 8; i++) ref_rf[i] = 0;
    repeat (2) @(negedge clk_i);
    do_reset();

    preload(3'd0, 8'h13);
    preload(3'd1, 8'hF0);
    preload(3'd2, 8'h20);
    preload(3'd3, 8'h00);
    preload(3'd4, 8'h00);
    preload(3'd5, 8'h0D);
    preload(3'd6, 8'h05);
    preload(3'd7, 8'h07);

    // Directed: carry on ADD, borrow on SUB, forwarding including rs==rt.
    send(OP_ADD, 3'd3, 3'd1, 3'd2);
    send(OP_XOR, 3'd4, 3'd3, 3'd1);
    send(OP_ADD, 3'd3, 3'd1, 3'd2);
    send(OP_XOR, 3'd4, 3'd3, 3'd3);
    send(OP_SUB, 3'd6, 3'd6, 3'd7);
    // MUL with the next instruction held through the busy window and forwarded.
    send(OP_MUL, 3'd5, 3'd0, 3'd5);
    send(OP_ADD, 3'd2, 3'd5, 3'd0);
    repeat (3) tick();
    preload(3'd3, 8'hFF);
    send(OP_MUL, 3'd1, 3'd3, 3'd3);
    repeat (10) tick();
    // Reset in the middle of a multiply, then a normal ADD.
    send(OP_MUL, 3'd7, 3'd3, 3'd3);
    repeat (3) tick();
    do_reset();
    send(OP_ADD, 3'd3, 3'd1, 3'd2);
    repeat (3) tick();

    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) do_reset();
      else if (r < 10) tick();
      else send(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    repeat (12) tick();
    chk("drain", 16'(q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
